// File: rtl/rv32i_lsu_if.sv
// Data-memory bus between the RV32I load/store unit and the data memory.
// The LSU sits on the master side; the memory model or fabric uses slave.
interface rv32i_lsu_if;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_gnt_i, mem_rvalid_i, mem_rdata_i
    );
endinterface

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: one outstanding access, request/grant then rvalid,
// with lane placement, load extension, legality checks and a timeout.
module rv32i_lsu #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               req_i,
    input  logic               re_i,
    input  logic               we_i,
    input  logic [2:0]         funct3_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        wdata_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [31:0]        rdata_o,
    rv32i_lsu_if.master        mem
);

    localparam int unsigned     CNT_W    = 10;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_DONE, S_ERR} state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_is_load;
    logic [2:0]       r_funct3;
    logic [1:0]       r_off;

    logic             w_illegal;
    logic             w_misaligned;
    logic             w_last;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic [31:0]      w_lane;
    logic [31:0]      w_ext;

    // funct3[1:0] encodes size (00 byte, 01 half, 10 word); bit 2 marks unsigned loads
    assign w_illegal = (re_i == we_i) ||
                       (re_i ? (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11)
                             : (funct3_i[2] || funct3_i[1:0] == 2'b11));
    assign w_misaligned = (funct3_i[1:0] == 2'b01 && addr_i[0]) ||
                          (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00);
    assign w_last = (r_cnt == CNT_LAST);
    assign w_lane = mem.mem_rdata_i >> {r_off, 3'b000};

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wdata_i;
        case (funct3_i[1:0])
            2'b00: begin
                w_be    = 4'b0001 << addr_i[1:0];
                w_wdata = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << addr_i[1:0];
                w_wdata = {2{wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_ext = w_lane;
        case (r_funct3)
            3'b000:  w_ext = {{24{w_lane[7]}}, w_lane[7:0]};
            3'b001:  w_ext = {{16{w_lane[15]}}, w_lane[15:0]};
            3'b100:  w_ext = {24'h0, w_lane[7:0]};
            3'b101:  w_ext = {16'h0, w_lane[15:0]};
            default: w_ext = w_lane;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_is_load       <= 1'b0;
            r_funct3        <= '0;
            r_off           <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
            err_o           <= 1'b0;
            rdata_o         <= '0;
            mem.mem_req_o   <= 1'b0;
            mem.mem_we_o    <= 1'b0;
            mem.mem_be_o    <= '0;
            mem.mem_addr_o  <= '0;
            mem.mem_wdata_o <= '0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_i) begin
                        busy_o    <= 1'b1;
                        r_is_load <= re_i;
                        r_funct3  <= funct3_i;
                        r_off     <= addr_i[1:0];
                        if (w_illegal || w_misaligned) begin
                            r_state <= S_ERR;
                            err_o   <= 1'b1;
                        end else begin
                            r_state         <= S_REQ;
                            r_cnt           <= '0;
                            mem.mem_req_o   <= 1'b1;
                            mem.mem_we_o    <= we_i;
                            mem.mem_be_o    <= w_be;
                            mem.mem_addr_o  <= {addr_i[31:2], 2'b00};
                            mem.mem_wdata_o <= w_wdata;
                        end
                    end
                end
                // A load granted on the final budgeted cycle has no room left to wait
                S_REQ: begin
                    if (mem.mem_gnt_i && !r_is_load) begin
                        mem.mem_req_o <= 1'b0;
                        r_state       <= S_DONE;
                        done_o        <= 1'b1;
                    end else if (w_last) begin
                        mem.mem_req_o <= 1'b0;
                        r_state       <= S_ERR;
                        err_o         <= 1'b1;
                    end else if (mem.mem_gnt_i) begin
                        mem.mem_req_o <= 1'b0;
                        r_state       <= S_WAIT;
                        r_cnt         <= r_cnt + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (mem.mem_rvalid_i) begin
                        rdata_o <= w_ext;
                        r_state <= S_DONE;
                        done_o  <= 1'b1;
                    end else if (w_last) begin
                        r_state <= S_ERR;
                        err_o   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/rv32i_lsu.md
RV32I_LSU -- requirements
Module: rv32i_lsu

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum cycles spent in REQ+WAIT before the access aborts with an error (range 1..1023).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rstn  input  1  synchronous, active-low reset.
REQ-004 req_i  input  1  execute stage requests an access; sampled only in IDLE.
REQ-005 re_i  input  1  load request (RE_1).
REQ-006 we_i  input  1  store request (WE_1).
REQ-007 funct3_i  input  3  access size/sign per RV32I LOAD/STORE funct3 codes (LS_BYTE, LS_HALFWORD, LS_WORD, LBU, LHU).
REQ-008 addr_i  input  32  byte address computed by the ALU (ALU_OP_ADD path).
REQ-009 wdata_i  input  32  rs2 store data.
REQ-010 busy_o  output  1  high whenever state is not IDLE.
REQ-011 done_o  output  1  one-cycle completion pulse.
REQ-012 err_o  output  1  one-cycle error pulse: misaligned, illegal, or timeout.
REQ-013 rdata_o  output  32  extended load result for the SEL_WB_MEM writeback path.
REQ-014 mem_req_o  output  1  data memory request.
REQ-015 mem_we_o  output  1  1 = write.
REQ-016 mem_be_o  output  4  byte enables.
REQ-017 mem_addr_o  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-018 mem_wdata_o  output  32  lane-replicated store data.
REQ-019 mem_gnt_i  input  1  memory accepts request this cycle.
REQ-020 mem_rvalid_i  input  1  load data valid this cycle.
REQ-021 mem_rdata_i  input  32  load data word.

Function
REQ-022 FSM states: IDLE, REQ, WAIT, DONE, ERR; exactly one active.
REQ-023 IDLE: req_i=1 latches re_i, we_i, funct3_i, addr_i and wdata_i; req_i is ignored in every other state.
REQ-024 Illegal request: re_i=we_i; load funct3 of 011/110/111; store funct3 not in 000..010. Each -> ERR, with no memory access.
REQ-025 Misaligned request: halfword with addr[0]=1, or word with addr[1:0]!=00 -> ERR, with no memory access.
REQ-026 Legal request: IDLE -> REQ on the next edge.
REQ-027 REQ: mem_req_o=1; mem_we_o, mem_be_o, mem_addr_o and mem_wdata_o are held stable until the cycle mem_gnt_i=1.
REQ-028 REQ with mem_gnt_i=1: store -> DONE; load -> WAIT; mem_req_o deasserts on the next edge.
REQ-029 WAIT with mem_rvalid_i=1: capture the extended data into rdata_o, then -> DONE.
REQ-030 mem_rvalid_i is ignored outside WAIT.
REQ-031 Byte enables: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
REQ-032 Store data: byte = {4{wdata[7:0]}}; half = {2{wdata[15:0]}}; word = wdata.
REQ-033 Load extraction: lane = mem_rdata_i >> (8*addr[1:0]).
REQ-034 Load extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
REQ-035 rdata_o holds its value until the next load completes; stores do not change it.
REQ-036 DONE: done_o=1 for one cycle, then -> IDLE.
REQ-037 ERR: err_o=1 for one cycle, then -> IDLE; rdata_o is unchanged.
REQ-038 Timeout counter: clears on entry to REQ and increments each cycle in REQ/WAIT; reaching TIMEOUT_CYCLES -> ERR, and mem_req_o drops on that edge.
REQ-039 Minimum latency: req_i at cycle N with gnt at N+1 gives store done_o at N+2; load with rvalid at N+2 gives done_o at N+3.
REQ-040 done_o and err_o are never high in the same cycle.

Reset
REQ-041 rstn=0 at a clock edge: state=IDLE; counter=0; rdata_o=0; busy_o, done_o, err_o, mem_req_o, mem_we_o=0; mem_be_o=0; mem_addr_o=0; mem_wdata_o=0.
REQ-042 Reset during REQ/WAIT aborts the access silently (no done_o, no err_o); a late mem_rvalid_i after reset is ignored.

Verification
REQ-043 LB addr=0x103, mem_rdata=0x80FF_FFFF, gnt N+1, rvalid N+2 -> mem_addr=0x100, be=1000, rdata_o=0xFFFF_FF80, done_o at N+3.
REQ-044 SH addr=0x202, wdata=0x1234_ABCD, gnt held low 3 cycles -> mem_req_o high 4 cycles, mem_wdata=0xABCD_ABCD, be=1100, single done_o.
REQ-045 LW addr=0x101 -> err_o one cycle at N+1, mem_req_o never asserted, rdata_o unchanged.
REQ-046 LHU addr=0x002, rdata=0xF00D_0000 -> rdata_o=0x0000_F00D; then SW -> rdata_o still 0x0000_F00D.
REQ-047 TIMEOUT_CYCLES=4, gnt never asserted -> err_o after 4 REQ cycles, busy_o low on the next cycle.
REQ-048 rstn=0 while in WAIT, with rvalid arriving next cycle -> all outputs 0, no done_o, IDLE accepts a new req_i.
